ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer between the word-addressed, combinational instruction ROM and the decode stage of the pipelined MIPS CPU.
- Owns the fetch PC and drives the ROM address every cycle.
- Buffers fetched words with their PCs in a small prefetch queue and hands them to decode over a valid/ready handshake.
- Accepts branch/jump/jr redirects that flush the queue, and detects the terminal self-loop (beq $zero,$zero,-1) to stop fetching.

---
 rtl/ifetch_pkg.sv | 24 ++
 rtl/ifetch_queue.sv | 72 +++++++
 rtl/ifetch_ctrl.sv | 94 +++++++++
 tb/tb_ifetch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Pure declarations: no latency, no flow control.
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // beq $zero,$zero,-1: the program's terminal self-loop
    localparam logic [31:0] HALT_WORD = 32'h1000_FFFF;
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO of {pc, instr}; head is registered storage, push-to-head 1 cycle.
// Push into a full queue only lands with a same-cycle pop; flush beats push and pop.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  fetch_ent_t             push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_ent_t             head_dat_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_ent_t       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    // DEPTH is a power of two, so the count MSB alone marks full
    assign full_o     = count_q[AW];
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !flush_i && !empty_o;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns fetch PC, feeds decode from the prefetch queue, 1-cycle ROM-to-decode latency.
// Fetch stalls while the queue is full with no pop; a redirect flushes and kills that cycle's handshake.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          HALT_DETECT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        halted,
    output logic        misalign_err
);

    fetch_state_e           state_q, state_d;
    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic                   misalign_q, misalign_d;
    logic                   push, pop;
    logic                   q_full, q_empty;
    logic [$clog2(DEPTH):0] q_count;
    fetch_ent_t             head;

    ifetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i ('{pc: fetch_pc_q, instr: rom_data}),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .head_dat_o (head),
        .count_o    (q_count),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    assign rom_addr     = fetch_pc_q;
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_q;

    assign if_valid    = (q_count != '0) && !redirect_valid;
    assign pop         = if_valid && if_ready;
    // Stale storage is never exposed: an empty queue presents zeros
    assign if_instr    = q_empty ? 32'h0 : head.instr;
    assign if_pc       = q_empty ? 32'h0 : head.pc;
    assign if_pc_plus4 = q_empty ? 32'h0 : head.pc + PC_STEP;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        if (redirect_valid) begin
            state_d    = RUN;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (!q_full || pop) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                        if (HALT_DETECT && (rom_data == HALT_WORD)) state_d = HALT;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a monitor scores every decode handshake against an expected-fetch queue.
// Direct checks cover reset values, latency, backpressure, redirect, halt, misalignment and PC wrap.
`timescale 1ns/1ps
module tb_ifetch_ctrl;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic        halted, misalign_err;

    logic [31:0] rom_mem [0:255];
    fetch_ent_t  exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    ifetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0), .HALT_DETECT(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .halted         (halted),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    always_comb rom_data = rom_mem[rom_addr[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: every completed handshake must match the next expected fetch
    always @(negedge clk) begin : monitor
        fetch_ent_t e;
        if (!reset && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL mon_extra: got pc %h expected no handshake", if_pc);
            end else begin
                e = exp_q.pop_front();
                check("mon_pc", if_pc, e.pc);
                check("mon_instr", if_instr, e.instr);
                check("mon_pc_plus4", if_pc_plus4, e.pc + 32'd4);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected fetch stream from a start PC; stops after the halt word
    task automatic push_epoch(input logic [31:0] start);
        logic [31:0] pc;
        logic [31:0] w;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < 64; i++) begin
            w = rom_mem[pc[9:2]];
            exp_q.push_back('{pc: pc, instr: w});
            if (w == HALT_WORD) break;
            pc = pc + 32'd4;
        end
    endtask

    task automatic do_reset(input logic rdy);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        if_ready       = rdy;
        step(2);
        reset = 1'b0;
        push_epoch(32'h0);
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        push_epoch({tgt[31:2], 2'b00});
        #1;
        check("redir_valid_forced_low", {31'b0, if_valid}, 32'd0);
        step(1);
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},    {31'b0, if_valid},     32'd0);
        check({tag, "_instr"},    if_instr,              32'd0);
        check({tag, "_pc"},       if_pc,                 32'd0);
        check({tag, "_pc_plus4"}, if_pc_plus4,           32'd0);
        check({tag, "_halted"},   {31'b0, halted},       32'd0);
        check({tag, "_misalign"}, {31'b0, misalign_err}, 32'd0);
        check({tag, "_rom_addr"}, rom_addr,              32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'h0;
        rom_mem[0]  = 32'h2004_0003;
        rom_mem[1]  = 32'h2005_0005;
        rom_mem[2]  = 32'h0085_3020;
        rom_mem[3]  = 32'hAFA6_0000;
        rom_mem[4]  = 32'h23BD_FFF8;
        rom_mem[5]  = 32'h8FA7_0008;
        rom_mem[6]  = {OP_BEQ, 5'd7, 5'd6, 16'h0002};
        rom_mem[7]  = 32'h2108_0001;
        rom_mem[8]  = {OP_J, 26'd11};
        rom_mem[9]  = {OP_JAL, 26'd16};
        rom_mem[10] = 32'h0000_0000;
        rom_mem[11] = 32'h0109_5020;
        rom_mem[12] = 32'hAC0A_0010;
        rom_mem[13] = 32'h8C0B_0010;
        rom_mem[14] = 32'h016A_6022;
        rom_mem[15] = 32'h03E0_0008;
        rom_mem[16] = 32'h2002_000A;
        rom_mem[17] = 32'h0000_000C;
        rom_mem[18] = HALT_WORD;

        // Reset release and first-fetch latency
        do_reset(1'b1);
        check_reset_outputs("reset");
        step(1);
        check("first_valid_not_early", {31'b0, if_valid}, 32'd0);
        step(1);
        check("first_valid", {31'b0, if_valid}, 32'd1);
        check("first_pc", if_pc, 32'h0);
        check("first_instr", if_instr, 32'h2004_0003);
        step(1);
        check("pc4_plus4", if_pc_plus4, 32'd8);
        step(4);

        // Backpressure: queue fills, fetch stalls, then full throughput
        do_reset(1'b0);
        step(12);
        check("bp_rom_addr_hold", rom_addr, 32'd16);
        check("bp_head_pc", if_pc, 32'd0);
        check("bp_valid", {31'b0, if_valid}, 32'd1);
        if_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check("bp_stream_pc", if_pc, 32'(4 * k));
            check("bp_stream_fetch", rom_addr, 32'(16 + 4 * k));
        end

        // Redirect with 3 entries queued and decode ready
        do_reset(1'b0);
        step(4);
        if_ready = 1'b1;
        do_redirect(32'h10);
        check("redir_empty_after", {31'b0, if_valid}, 32'd0);
        step(1);
        check("redir_pc", if_pc, 32'd16);
        check("redir_instr", if_instr, 32'h23BD_FFF8);

        // Halt on self-loop word at PC 12
        rom_mem[3] = HALT_WORD;
        do_reset(1'b0);
        step(4);
        check("halt_not_yet", {31'b0, halted}, 32'd0);
        step(1);
        check("halt_rise", {31'b0, halted}, 32'd1);
        check("halt_rom_addr", rom_addr, 32'd16);
        if_ready = 1'b1;
        step(6);
        check("halt_drained", {31'b0, if_valid}, 32'd0);
        check("halt_rom_addr_frozen", rom_addr, 32'd16);
        check("halt_held", {31'b0, halted}, 32'd1);
        do_redirect(32'h0);
        check("halt_cleared", {31'b0, halted}, 32'd0);
        step(1);
        check("halt_resume_pc", if_pc, 32'd0);
        rom_mem[3] = 32'hAFA6_0000;

        // Misaligned redirect is sticky until reset
        do_reset(1'b1);
        step(4);
        do_redirect(32'h0000_0013);
        check("misalign_set", {31'b0, misalign_err}, 32'd1);
        step(1);
        check("misalign_pc", if_pc, 32'd16);
        do_redirect(32'h20);
        check("misalign_sticky", {31'b0, misalign_err}, 32'd1);
        step(2);

        // Reset mid-stream, queue full, with a misaligned redirect in the same cycle
        do_reset(1'b0);
        check("rst_clears_misalign", {31'b0, misalign_err}, 32'd0);
        step(8);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        if_ready       = 1'b1;
        step(1);
        check_reset_outputs("midrst");
        reset          = 1'b0;
        redirect_valid = 1'b0;
        push_epoch(32'h0);
        step(2);
        check("midrst_restart_pc", if_pc, 32'd0);

        // PC wrap at the top of the address space
        step(3);
        do_redirect(32'hFFFF_FFFC);
        step(1);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", if_pc_plus4, 32'h0);
        check("wrap_rom_addr", rom_addr, 32'h0);
        step(1);
        check("wrap_next_pc", if_pc, 32'h0);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
